hazard_stall_ctrl: RTL and testbench

//  Pipeline stall/bubble scheduler in the ID stage of the 5-stage MIPS pipeline.
//  - Detects load-use hazards and branch/jr-in-ID operand hazards that forwarding cannot resolve.
//  - Sequences a multi-cycle mult/div unit through a busy counter.
//  - Honours an external memory freeze.
//  - Drives the PC, IF/ID and ID/EX hold and bubble controls.

---
 rtl/hazard_stall_ctrl_pkg.sv | 19 +
 rtl/hazard_stall_ctrl_if.sv | 43 ++++
 rtl/hazard_stall_ctrl_muldiv_busy_cnt.sv | 27 ++
 rtl/hazard_stall_ctrl.sv | 91 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and helpers for the ID-stage hazard/stall controller.
// Package hazard_pkg: stall cause encoding and register-match helper.
package hazard_pkg;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      FREEZE = 2'd1,
      DATA   = 2'd2,
      MULDIV = 2'd3
   } hz_cause_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // $zero is hard-wired, so a write to it never creates a dependency.
   function automatic logic reg_match(input logic [4:0] wr_addr, input logic [4:0] rd_addr);
      return (wr_addr != REG_ZERO) && (wr_addr == rd_addr);
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ID-stage hazard bus: pipeline status in, stall/bubble controls out.
interface hazard_stall_ctrl_if;
   import hazard_pkg::*;

   logic       mem_wait;
   logic [4:0] id_rs_addr;
   logic [4:0] id_rt_addr;
   logic       id_uses_rs;
   logic       id_uses_rt;
   logic       id_is_branch;
   logic       id_is_muldiv;
   logic       id_reads_hilo;
   logic       id_ex_RegWrite;
   logic       id_ex_MemRead;
   logic [4:0] id_ex_write_addr;
   logic       ex_mem_MemRead;
   logic [4:0] ex_mem_write_addr;

   logic       pc_hold;
   logic       if_id_hold;
   logic       id_ex_hold;
   logic       id_ex_bubble;
   logic       muldiv_start;
   logic       muldiv_busy;
   hz_cause_t  stall_cause;

   modport master (
      output mem_wait, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_is_branch,
             id_is_muldiv, id_reads_hilo, id_ex_RegWrite, id_ex_MemRead, id_ex_write_addr,
             ex_mem_MemRead, ex_mem_write_addr,
      input  pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, muldiv_start, muldiv_busy,
             stall_cause
   );

   modport slave (
      input  mem_wait, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_is_branch,
             id_is_muldiv, id_reads_hilo, id_ex_RegWrite, id_ex_MemRead, id_ex_write_addr,
             ex_mem_MemRead, ex_mem_write_addr,
      output pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, muldiv_start, muldiv_busy,
             stall_cause
   );

endinterface

// File: rtl/hazard_stall_ctrl_muldiv_busy_cnt.sv
// Busy counter for the multi-cycle mult/div unit: loads LATENCY on start,
// then counts down to zero. Runs through memory freezes.
module muldiv_busy_cnt #(
   parameter int unsigned LATENCY = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy
);

   localparam int unsigned CNT_W = $clog2(LATENCY + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset)
         cnt <= '0;
      else if (start)
         cnt <= CNT_W'(LATENCY);
      else if (cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall/bubble scheduler: load-use and branch-in-ID hazards, mult/div
// busy tracking, memory freeze. Optional perf counters via HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MULDIV_LATENCY = 32
`ifdef HAZARD_PERF_CNT_EN
   , parameter int unsigned PERF_W = 32
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   hazard_stall_ctrl_if.slave    bus
`ifdef HAZARD_PERF_CNT_EN
   , output logic [PERF_W-1:0]   stall_cycles
   , output logic [PERF_W-1:0]   freeze_cycles
`endif
);

   logic      load_use_hz;
   logic      branch_hz;
   logic      data_hz;
   logic      md_hz;
   logic      busy_raw;
   logic      start;
   hz_cause_t cause;

   always_comb begin
      load_use_hz = bus.id_ex_MemRead &&
                    ((bus.id_uses_rs && reg_match(bus.id_ex_write_addr, bus.id_rs_addr)) ||
                     (bus.id_uses_rt && reg_match(bus.id_ex_write_addr, bus.id_rt_addr)));
      // Branches resolve in ID: any producer in EX, or a load still in MEM, is too late to forward.
      branch_hz   = bus.id_is_branch &&
                    ((bus.id_ex_RegWrite &&
                      (reg_match(bus.id_ex_write_addr, bus.id_rs_addr) ||
                       reg_match(bus.id_ex_write_addr, bus.id_rt_addr))) ||
                     (bus.ex_mem_MemRead &&
                      (reg_match(bus.ex_mem_write_addr, bus.id_rs_addr) ||
                       reg_match(bus.ex_mem_write_addr, bus.id_rt_addr))));
      data_hz     = load_use_hz || branch_hz;
      md_hz       = busy_raw && (bus.id_is_muldiv || bus.id_reads_hilo);
   end

   always_comb begin
      cause = NONE;
      if (!reset)
         cause = NONE;
      else if (bus.mem_wait)
         cause = FREEZE;
      else if (data_hz)
         cause = DATA;
      else if (md_hz)
         cause = MULDIV;
   end

   assign start = reset && bus.id_is_muldiv && (cause == NONE);

   muldiv_busy_cnt #(
      .LATENCY(MULDIV_LATENCY)
   ) u_busy_cnt (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .busy  (busy_raw)
   );

   always_comb begin
      bus.pc_hold      = (cause != NONE);
      bus.if_id_hold   = (cause != NONE);
      bus.id_ex_hold   = (cause == FREEZE);
      bus.id_ex_bubble = (cause == DATA) || (cause == MULDIV);
      bus.muldiv_start = start;
      bus.muldiv_busy  = reset && busy_raw;
      bus.stall_cause  = cause;
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cycles  <= '0;
         freeze_cycles <= '0;
      end else begin
         if ((cause == DATA) || (cause == MULDIV))
            stall_cycles <= stall_cycles + PERF_W'(1);
         if (cause == FREEZE)
            freeze_cycles <= freeze_cycles + PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MULDIV_LATENCY = 4).
// Perf-counter checks run only when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_stall_ctrl;
   import hazard_pkg::*;

   // Observed vector: {pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, muldiv_start, muldiv_busy, cause[1:0]}
   localparam logic [7:0] O_NONE  = 8'b0000_00_00;
   localparam logic [7:0] O_DATA  = 8'b1101_00_10;
   localparam logic [7:0] O_MD    = 8'b1101_01_11;
   localparam logic [7:0] O_FRZ   = 8'b1110_00_01;
   localparam logic [7:0] O_START = 8'b0000_10_00;
   localparam logic [7:0] O_BUSY  = 8'b0000_01_00;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   hazard_stall_ctrl_if bus ();

`ifdef HAZARD_PERF_CNT_EN
   logic [3:0] stall_cycles;
   logic [3:0] freeze_cycles;
`endif

   hazard_stall_ctrl #(
      .MULDIV_LATENCY(4)
`ifdef HAZARD_PERF_CNT_EN
      , .PERF_W(4)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles  (stall_cycles)
      , .freeze_cycles (freeze_cycles)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {bus.pc_hold, bus.if_id_hold, bus.id_ex_hold, bus.id_ex_bubble,
              bus.muldiv_start, bus.muldiv_busy, bus.stall_cause};
   endfunction

   task automatic clear_in();
      bus.mem_wait = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0;
      bus.id_uses_rs = 0; bus.id_uses_rt = 0; bus.id_is_branch = 0;
      bus.id_is_muldiv = 0; bus.id_reads_hilo = 0; bus.id_ex_RegWrite = 0;
      bus.id_ex_MemRead = 0; bus.id_ex_write_addr = 0;
      bus.ex_mem_MemRead = 0; bus.ex_mem_write_addr = 0;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] o;
      reset = 0;
      clear_in();
      bus.mem_wait = 1; bus.id_is_muldiv = 1;
      bus.id_ex_MemRead = 1; bus.id_ex_write_addr = 8; bus.id_uses_rs = 1; bus.id_rs_addr = 8;
      for (int i = 0; i < 2; i++) begin
         #1; o = outs(); checks++;
         if (o !== O_NONE) begin failures++; $display("FAIL reset_low[%0d]: got %b exp %b", i, o, O_NONE); end
         cycle();
      end
      reset = 1;
      clear_in();
      #1; o = outs(); checks++;
      if (o !== O_NONE) begin failures++; $display("FAIL reset_release: got %b exp %b", o, O_NONE); end
      cycle();
   endtask

   task automatic test_load_use();
      logic [7:0] o;
      clear_in();
      bus.id_ex_MemRead = 1; bus.id_ex_RegWrite = 1; bus.id_ex_write_addr = 8;
      bus.id_uses_rs = 1; bus.id_rs_addr = 8; bus.id_uses_rt = 1; bus.id_rt_addr = 9;
      #1; o = outs(); checks++;
      if (o !== O_DATA) begin failures++; $display("FAIL load_use_stall: got %b exp %b", o, O_DATA); end
      cycle();
      clear_in();
      bus.ex_mem_MemRead = 1; bus.ex_mem_write_addr = 8;
      bus.id_uses_rs = 1; bus.id_rs_addr = 8; bus.id_uses_rt = 1; bus.id_rt_addr = 9;
      #1; o = outs(); checks++;
      if (o !== O_NONE) begin failures++; $display("FAIL load_use_release: got %b exp %b", o, O_NONE); end
      cycle();
      clear_in();
      bus.id_ex_MemRead = 1; bus.id_ex_write_addr = 8; bus.id_uses_rt = 0; bus.id_rt_addr = 8;
      #1; o = outs(); checks++;
      if (o !== O_NONE) begin failures++; $display("FAIL load_use_rt_unused: got %b exp %b", o, O_NONE); end
      cycle();
   endtask

   task automatic test_branch();
      logic [7:0] o;
      clear_in();
      bus.id_is_branch = 1; bus.id_rs_addr = 8; bus.id_rt_addr = 3;
      bus.id_ex_MemRead = 1; bus.id_ex_RegWrite = 1; bus.id_ex_write_addr = 8;
      #1; o = outs(); checks++;
      if (o !== O_DATA) begin failures++; $display("FAIL branch_ex_stall: got %b exp %b", o, O_DATA); end
      cycle();
      bus.id_ex_MemRead = 0; bus.id_ex_RegWrite = 0; bus.id_ex_write_addr = 0;
      bus.ex_mem_MemRead = 1; bus.ex_mem_write_addr = 8;
      #1; o = outs(); checks++;
      if (o !== O_DATA) begin failures++; $display("FAIL branch_mem_stall: got %b exp %b", o, O_DATA); end
      cycle();
      bus.ex_mem_MemRead = 0; bus.ex_mem_write_addr = 0;
      #1; o = outs(); checks++;
      if (o !== O_NONE) begin failures++; $display("FAIL branch_release: got %b exp %b", o, O_NONE); end
      cycle();
      // ALU result in EX feeding rt of a branch
      bus.id_ex_RegWrite = 1; bus.id_ex_write_addr = 3;
      #1; o = outs(); checks++;
      if (o !== O_DATA) begin failures++; $display("FAIL branch_alu_rt: got %b exp %b", o, O_DATA); end
      cycle();
      clear_in();
      bus.id_is_branch = 1; bus.id_rs_addr = 0; bus.id_rt_addr = 0;
      bus.id_ex_MemRead = 1; bus.id_ex_RegWrite = 1; bus.id_ex_write_addr = 0;
      bus.ex_mem_MemRead = 1; bus.ex_mem_write_addr = 0;
      bus.id_uses_rs = 1; bus.id_uses_rt = 1;
      #1; o = outs(); checks++;
      if (o !== O_NONE) begin failures++; $display("FAIL branch_reg0: got %b exp %b", o, O_NONE); end
      cycle();
   endtask

   task automatic test_muldiv();
      logic [7:0] o;
      clear_in();
      bus.id_is_muldiv = 1;
      #1; o = outs(); checks++;
      if (o !== O_START) begin failures++; $display("FAIL mult_issue: got %b exp %b", o, O_START); end
      cycle();
      clear_in();
      bus.id_reads_hilo = 1;
      for (int i = 0; i < 4; i++) begin
         #1; o = outs(); checks++;
         if (o !== O_MD) begin failures++; $display("FAIL mfhi_wait[%0d]: got %b exp %b", i, o, O_MD); end
         cycle();
      end
      #1; o = outs(); checks++;
      if (o !== O_NONE) begin failures++; $display("FAIL mfhi_proceed: got %b exp %b", o, O_NONE); end
      cycle();
   endtask

   task automatic test_back_to_back();
      logic [7:0] o;
      clear_in();
      bus.id_is_muldiv = 1;
      #1; o = outs(); checks++;
      if (o !== O_START) begin failures++; $display("FAIL b2b_first: got %b exp %b", o, O_START); end
      cycle();
      for (int i = 0; i < 4; i++) begin
         #1; o = outs(); checks++;
         if (o !== O_MD) begin failures++; $display("FAIL b2b_blocked[%0d]: got %b exp %b", i, o, O_MD); end
         cycle();
      end
      #1; o = outs(); checks++;
      if (o !== O_START) begin failures++; $display("FAIL b2b_second: got %b exp %b", o, O_START); end
      cycle();
      clear_in();
      for (int i = 0; i < 4; i++) cycle();
   endtask

   task automatic test_freeze();
      logic [7:0] o;
      clear_in();
      bus.mem_wait = 1; bus.id_is_muldiv = 1;
      #1; o = outs(); checks++;
      if (o !== O_FRZ) begin failures++; $display("FAIL freeze_no_start: got %b exp %b", o, O_FRZ); end
      cycle();
      clear_in();
      bus.id_is_muldiv = 1;
      #1; o = outs(); checks++;
      if (o !== O_START) begin failures++; $display("FAIL freeze_mult_issue: got %b exp %b", o, O_START); end
      cycle();
      clear_in();
      bus.mem_wait = 1; bus.id_reads_hilo = 1;
      bus.id_ex_MemRead = 1; bus.id_ex_write_addr = 8; bus.id_uses_rs = 1; bus.id_rs_addr = 8;
      for (int i = 0; i < 4; i++) begin
         #1; o = outs(); checks++;
         if (o !== (O_FRZ | O_BUSY)) begin failures++; $display("FAIL freeze_data[%0d]: got %b exp %b", i, o, O_FRZ | O_BUSY); end
         cycle();
      end
      clear_in();
      bus.id_reads_hilo = 1;
      #1; o = outs(); checks++;
      if (o !== O_NONE) begin failures++; $display("FAIL freeze_counter_drained: got %b exp %b", o, O_NONE); end
      cycle();
   endtask

   task automatic test_reset_mid_muldiv();
      logic [7:0] o;
      clear_in();
      bus.id_is_muldiv = 1;
      cycle();
      clear_in();
      #1; o = outs(); checks++;
      if (o !== O_BUSY) begin failures++; $display("FAIL mid_busy_cnt4: got %b exp %b", o, O_BUSY); end
      cycle();
      reset = 0;
      bus.id_reads_hilo = 1; bus.id_is_muldiv = 1;
      for (int i = 0; i < 2; i++) begin
         #1; o = outs(); checks++;
         if (o !== O_NONE) begin failures++; $display("FAIL mid_reset_low[%0d]: got %b exp %b", i, o, O_NONE); end
         cycle();
      end
      reset = 1;
      bus.id_is_muldiv = 0;
      #1; o = outs(); checks++;
      if (o !== O_NONE) begin failures++; $display("FAIL mid_reset_busy_cleared: got %b exp %b", o, O_NONE); end
      cycle();
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf_cnt();
      reset = 0;
      clear_in();
      cycle();
      reset = 1;
      checks++;
      if (stall_cycles !== 4'd0 || freeze_cycles !== 4'd0) begin
         failures++; $display("FAIL perf_reset: got %0d/%0d exp 0/0", stall_cycles, freeze_cycles);
      end
      test_load_use();
      test_muldiv();
      checks++;
      if (stall_cycles !== 4'd5 || freeze_cycles !== 4'd0) begin
         failures++; $display("FAIL perf_stalls: got %0d/%0d exp 5/0", stall_cycles, freeze_cycles);
      end
      clear_in();
      bus.mem_wait = 1;
      for (int i = 0; i < 15; i++) cycle();
      checks++;
      if (freeze_cycles !== 4'd15) begin
         failures++; $display("FAIL perf_freeze_max: got %0d exp 15", freeze_cycles);
      end
      cycle();
      checks++;
      if (freeze_cycles !== 4'd0 || stall_cycles !== 4'd5) begin
         failures++; $display("FAIL perf_freeze_wrap: got %0d/%0d exp 5/0", stall_cycles, freeze_cycles);
      end
      clear_in();
      cycle();
   endtask
`endif

   initial begin
      reset = 0;
      clear_in();
      #1;
      test_reset();
      test_load_use();
      test_branch();
      test_muldiv();
      test_back_to_back();
      test_freeze();
      test_reset_mid_muldiv();
`ifdef HAZARD_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
